// File: rtl/request_encoder_pkg.sv
// request_encoder_pkg: shared sizes and FSM state type for the request encoder.
package request_encoder_pkg;
    localparam int N = 8;
    localparam int W = $clog2(N);
    typedef enum logic {IDLE, VALID} state_t;
endpackage

// File: rtl/request_encoder_if.sv
// request_encoder_if: request lines plus the encoded-index valid/ready stream.
interface request_encoder_if;
    import request_encoder_pkg::*;
    logic [N-1:0] req;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_idx;
    logic         busy;
    modport master (input req, out_ready, output out_valid, out_idx, busy);
    modport slave (output req, out_ready, input out_valid, out_idx, busy);
endinterface

// File: rtl/request_encoder_priority_pick.sv
// priority_pick: first set bit of mask found by searching upward from start, wrapping modulo N.
module priority_pick
    import request_encoder_pkg::*;
(
    input  logic [N-1:0] mask,
    input  logic [W-1:0] start,
    output logic [W-1:0] idx,
    output logic         any
);
    always_comb begin
        idx = '0;
        any = |mask;
        // Walk from the farthest offset down so the nearest hit is assigned last.
        for (int k = N - 1; k >= 0; k--) begin
            if (mask[start + W'(k)]) idx = start + W'(k);
        end
    end
endmodule

// File: rtl/request_encoder.sv
// request_encoder: sticky request set encoded into one 3-bit index per valid/ready transfer.
// Define ROUND_ROBIN_EN for rotating priority; default is fixed lowest-index-first.
module request_encoder
    import request_encoder_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    request_encoder_if.master bus
);
    logic [N-1:0] pending;
    logic [N-1:0] grant_mask;
    logic [W-1:0] sel;
    logic [W-1:0] start;
    logic [W-1:0] idx_q;
    logic         any;
    logic         load;
    state_t       state;
    state_t       state_nx;

`ifdef ROUND_ROBIN_EN
    logic [W-1:0] rr_ptr;
    assign start = rr_ptr;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) rr_ptr <= '0;
        else if (load) rr_ptr <= sel + W'(1);
    end
`else
    assign start = '0;
`endif

    priority_pick u_pick (
        .mask  (pending),
        .start (start),
        .idx   (sel),
        .any   (any)
    );

    always_comb begin
        load       = 1'b0;
        state_nx   = state;
        grant_mask = '0;
        // A new index loads from IDLE or on an accept edge, giving back-to-back transfers.
        load       = any && (state == IDLE || bus.out_ready);
        grant_mask = load ? (N'(1) << sel) : '0;
        state_nx   = load ? VALID : (state == VALID && bus.out_ready) ? IDLE : state;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending <= '0;
            state   <= IDLE;
            idx_q   <= '0;
        end else begin
            pending <= (pending & ~grant_mask) | bus.req;
            state   <= state_nx;
            if (load) idx_q <= sel;
        end
    end

    assign bus.out_valid = (state == VALID);
    assign bus.out_idx   = idx_q;
    assign bus.busy      = |pending || bus.out_valid;
endmodule

// File: tb/tb_request_encoder.sv
// tb_request_encoder: randomized and directed checks against a set-based reference model.
module tb_request_encoder;
    import request_encoder_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    request_encoder_if bus ();

    request_encoder dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    int errs = 0;
    int checks = 0;
    logic [N-1:0] m_pend;
    bit m_valid;
    int m_idx;
    int m_rr;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int pick();
        for (int k = 0; k < N; k++) begin
            int j = (m_rr + k) % N;
            if (m_pend[j]) return j;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_pend = '0;
        m_valid = 0;
        m_idx = 0;
        m_rr = 0;
    endtask

    task automatic compare();
        chk("out_valid", int'(bus.out_valid), int'(m_valid));
        chk("out_idx", int'(bus.out_idx), m_idx);
        chk("busy", int'(bus.busy), int'(m_pend != 0 || m_valid));
    endtask

    task automatic step(input logic [N-1:0] r, input logic rd);
        int p;
        bus.req = r;
        bus.out_ready = rd;
        @(posedge clk);
        p = pick();
        if (p >= 0 && (!m_valid || rd)) begin
            m_valid = 1;
            m_idx = p;
            m_pend[p] = 1'b0;
`ifdef ROUND_ROBIN_EN
            m_rr = (p + 1) % N;
`endif
        end else if (m_valid && rd) begin
            m_valid = 0;
        end
        m_pend = m_pend | r;
        #1;
        compare();
    endtask

    task automatic do_reset();
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        chk("rst_valid_now", int'(bus.out_valid), 0);
        chk("rst_busy_now", int'(bus.busy), 0);
        compare();
        @(posedge clk);
        #1;
        compare();
        reset = 1'b0;
    endtask

    initial begin
        bus.req = '0;
        bus.out_ready = 1'b0;
        model_reset();
        #1;
        chk("reset_idx", int'(bus.out_idx), 0);
        compare();
        @(posedge clk);
        #1;
        reset = 1'b0;

        // single request, index 5
        step(8'h20, 1);
        chk("single_wait", int'(bus.out_valid), 0);
        step(8'h00, 1);
        chk("single_valid", int'(bus.out_valid), 1);
        chk("single_idx", int'(bus.out_idx), 5);
        step(8'h00, 1);
        chk("single_busy", int'(bus.busy), 0);

        // back-to-back 0,2,7
        do_reset();
        step(8'h85, 1);
        step(8'h00, 1);
        chk("b2b_0", int'(bus.out_idx), 0);
        step(8'h00, 1);
        chk("b2b_2", int'(bus.out_idx), 2);
        step(8'h00, 1);
        chk("b2b_7", int'(bus.out_idx), 7);
        chk("b2b_valid", int'(bus.out_valid), 1);
        step(8'h00, 1);
        chk("b2b_done", int'(bus.out_valid), 0);

        // backpressure on index 3
        do_reset();
        step(8'h08, 0);
        for (int i = 0; i < 5; i++) begin
            step(8'h00, 0);
            chk("bp_valid", int'(bus.out_valid), 1);
            chk("bp_idx", int'(bus.out_idx), 3);
        end
        step(8'h00, 1);
        chk("bp_accept", int'(bus.out_valid), 0);

        // set wins over grant clear on index 4
        do_reset();
        step(8'h10, 1);
        step(8'h10, 1);
        chk("coll_first", int'(bus.out_idx), 4);
        step(8'h00, 1);
        chk("coll_again_v", int'(bus.out_valid), 1);
        chk("coll_again", int'(bus.out_idx), 4);
        step(8'h00, 1);
        chk("coll_done", int'(bus.out_valid), 0);

        // held requests 0 and 1
        do_reset();
        step(8'h03, 1);
        for (int i = 0; i < 4; i++) begin
            step(8'h03, 1);
`ifdef ROUND_ROBIN_EN
            chk("rr_idx", int'(bus.out_idx), i % 2);
`else
            chk("fixed_idx", int'(bus.out_idx), 0);
`endif
        end

        // mid-stream reset with everything pending
        do_reset();
        step(8'hFF, 0);
        step(8'h00, 0);
        chk("full_idx", int'(bus.out_idx), 0);
        do_reset();
        for (int i = 0; i < 3; i++) begin
            step(8'h00, 1);
            chk("post_rst_valid", int'(bus.out_valid), 0);
        end

        for (int i = 0; i < 500; i++) begin
            logic [N-1:0] r;
            r = ($urandom_range(0, 3) == 0) ? N'($urandom_range(0, 255)) : '0;
            if ($urandom_range(0, 99) == 0) do_reset();
            else step(r, $urandom_range(0, 3) != 0);
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
